if_id_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register of the MIPS-32 core.

---
 rtl/if_id_stage.sv | 166 ++++++++++++++++
 tb/tb_if_id_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// MIPS-32 instruction fetch with req/ack imem handshake, PC redirect/kill, stall hold buffer and IF/ID register.
// Optional IF_PERF_CNT_EN adds fetch and stall counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_op_code,
  output logic        id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_kill, w_kill_nxt;
  logic [31:0] r_tgt, w_tgt_nxt;
  logic [31:0] r_hold_instr, w_hold_instr_nxt;
  logic [31:0] r_hold_pc4, w_hold_pc4_nxt;
  logic [31:0] r_id_instr, w_id_instr_nxt;
  logic [31:0] r_id_pc4, w_id_pc4_nxt;
  logic        r_id_valid, w_id_valid_nxt;
  logic        w_fetch_acc;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  // Branch resolves in EX, so it is older than the jump sitting in IF/ID.
  assign w_redirect = branch_taken | jump;
  assign w_target   = branch_taken ? branch_target
                                   : {r_id_pc4[31:28], jump_index, 2'b00};
  assign w_pc_plus4 = r_pc + 32'd4;

  assign imem_req    = (r_state == S_FETCH) & ~rst;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign id_instr    = r_id_instr;
  assign id_pc_plus4 = r_id_pc4;
  assign id_op_code  = r_id_instr[31:26];
  assign id_valid    = r_id_valid;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_kill_nxt       = r_kill;
    w_tgt_nxt        = r_tgt;
    w_hold_instr_nxt = r_hold_instr;
    w_hold_pc4_nxt   = r_hold_pc4;
    w_id_instr_nxt   = r_id_instr;
    w_id_pc4_nxt     = r_id_pc4;
    w_id_valid_nxt   = r_id_valid;
    w_fetch_acc      = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (imem_ack) begin
          if (r_kill) begin
            // Response to a stale address; a newer redirect overrides the saved one.
            w_pc_nxt   = w_redirect ? w_target : r_tgt;
            w_kill_nxt = 1'b0;
          end else if (w_redirect) begin
            w_pc_nxt = w_target;
          end else begin
            w_fetch_acc = 1'b1;
            w_pc_nxt    = w_pc_plus4;
            if (!stall) begin
              w_id_instr_nxt = imem_rdata;
              w_id_pc4_nxt   = w_pc_plus4;
              w_id_valid_nxt = 1'b1;
            end else begin
              w_hold_instr_nxt = imem_rdata;
              w_hold_pc4_nxt   = w_pc_plus4;
              w_state_nxt      = S_HOLD;
            end
          end
        end else if (w_redirect) begin
          // imem_addr must stay stable until the ack, so defer the PC change.
          w_kill_nxt = 1'b1;
          w_tgt_nxt  = w_target;
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_FETCH;
        end else if (!stall) begin
          w_id_instr_nxt = r_hold_instr;
          w_id_pc4_nxt   = r_hold_pc4;
          w_id_valid_nxt = 1'b1;
          w_state_nxt    = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase

    if (w_redirect | flush) begin
      w_id_valid_nxt = 1'b0;
      w_id_instr_nxt = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_tgt        <= 32'd0;
      r_hold_instr <= NOP_INSTR;
      r_hold_pc4   <= 32'd0;
      r_id_instr   <= NOP_INSTR;
      r_id_pc4     <= 32'd0;
      r_id_valid   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_kill       <= w_kill_nxt;
      r_tgt        <= w_tgt_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_hold_pc4   <= w_hold_pc4_nxt;
      r_id_instr   <= w_id_instr_nxt;
      r_id_pc4     <= w_id_pc4_nxt;
      r_id_valid   <= w_id_valid_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch, r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      r_perf_fetch <= r_perf_fetch + {31'd0, w_fetch_acc};
      r_perf_stall <= r_perf_stall + {31'd0, stall & r_id_valid};
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`else
  logic w_unused_fetch_acc;
  assign w_unused_fetch_acc = w_fetch_acc;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed table-driven bench for if_id_stage: one vector per clock, outputs checked 1ns after the edge.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, branch_taken, jump, imem_ack;
  logic [31:0] branch_target, imem_rdata;
  logic [25:0] jump_index;
  logic        imem_req, id_valid;
  logic [31:0] imem_addr, pc, id_instr, id_pc_plus4;
  logic [5:0]  id_op_code;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .id_instr      (id_instr),
    .id_pc_plus4   (id_pc_plus4),
    .id_op_code    (id_op_code),
    .id_valid      (id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [25:0] ji;
    logic        ack;
    logic [31:0] rd;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_req;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic f, input logic b, input logic [31:0] bt,
                     input logic j, input logic [25:0] ji, input logic a, input logic [31:0] rd,
                     input logic [31:0] epc, input logic [31:0] ein, input logic [31:0] ep4,
                     input logic ev, input logic erq);
    vec_t v;
    v.stall = s; v.flush = f; v.br = b; v.bt = bt; v.jmp = j; v.ji = ji; v.ack = a; v.rd = rd;
    v.e_pc = epc; v.e_instr = ein; v.e_pc4 = ep4; v.e_valid = ev; v.e_req = erq;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; branch_taken = 0; branch_target = 0;
    jump = 0; jump_index = 0; imem_ack = 0; imem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] bt, input logic a, input logic [31:0] rd);
    stall = s; branch_taken = b; branch_target = bt; imem_ack = a; imem_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    chk("rst_pc", -1, pc, 32'h0);
    chk("rst_req", -1, {31'd0, imem_req}, 32'd0);
    chk("rst_valid", -1, {31'd0, id_valid}, 32'd0);
    chk("rst_instr", -1, id_instr, 32'h0);
    chk("rst_pc4", -1, id_pc_plus4, 32'h0);
    rst = 0;
    #1;
    chk("req_after_rst", -1, {31'd0, imem_req}, 32'd1);
    chk("addr_after_rst", -1, imem_addr, 32'h0);

    //  stall flush br  bt            jmp ji         ack rdata          pc            instr          pc4          v  req
    add(0, 0, 0, 32'h0,          0, 26'h0,       1, 32'h0400_0000, 32'h4,        32'h0400_0000, 32'h4,        1, 1);
    add(0, 0, 0, 32'h0,          0, 26'h0,       1, 32'h0800_0004, 32'h8,        32'h0800_0004, 32'h8,        1, 1);
    add(0, 0, 0, 32'h0,          0, 26'h0,       1, 32'h8C00_0008, 32'hC,        32'h8C00_0008, 32'hC,        1, 1);
    add(0, 0, 0, 32'h0,          0, 26'h0,       0, 32'h0,         32'hC,        32'h8C00_0008, 32'hC,        1, 1);
    add(1, 0, 0, 32'h0,          0, 26'h0,       1, 32'hAC00_000C, 32'h10,       32'h8C00_0008, 32'hC,        1, 0);
    add(1, 0, 0, 32'h0,          0, 26'h0,       0, 32'h0,         32'h10,       32'h8C00_0008, 32'hC,        1, 0);
    add(1, 0, 0, 32'h0,          0, 26'h0,       0, 32'h0,         32'h10,       32'h8C00_0008, 32'hC,        1, 0);
    add(0, 0, 0, 32'h0,          0, 26'h0,       0, 32'h0,         32'h10,       32'hAC00_000C, 32'h10,       1, 1);
    add(0, 1, 0, 32'h0,          0, 26'h0,       0, 32'h0,         32'h10,       32'h0,         32'h10,       0, 1);
    add(0, 0, 0, 32'h0,          0, 26'h0,       1, 32'h1000_0010, 32'h14,       32'h1000_0010, 32'h14,       1, 1);
    add(0, 0, 1, 32'h1000_0004,  0, 26'h0,       1, 32'h1234_5678, 32'h1000_0004, 32'h0,        32'h14,       0, 1);
    add(0, 0, 0, 32'h0,          0, 26'h0,       1, 32'h0800_0040, 32'h1000_0008, 32'h0800_0040, 32'h1000_0008, 1, 1);
    add(0, 0, 0, 32'h0,          1, 26'h40,      0, 32'h0,         32'h1000_0008, 32'h0,        32'h1000_0008, 0, 1);
    add(0, 0, 0, 32'h0,          0, 26'h0,       1, 32'hDEAD_BEEF, 32'h1000_0100, 32'h0,        32'h1000_0008, 0, 1);
    add(0, 0, 0, 32'h0,          0, 26'h0,       1, 32'h2400_0001, 32'h1000_0104, 32'h2400_0001, 32'h1000_0104, 1, 1);
    add(0, 0, 1, 32'h200,        1, 26'h3FF_FFFF, 1, 32'h5555_5555, 32'h200,     32'h0,         32'h1000_0104, 0, 1);
    add(0, 0, 1, 32'h300,        0, 26'h0,       0, 32'h0,         32'h200,      32'h0,         32'h1000_0104, 0, 1);
    add(0, 0, 0, 32'h0,          0, 26'h0,       0, 32'h0,         32'h200,      32'h0,         32'h1000_0104, 0, 1);
    add(0, 0, 0, 32'h0,          0, 26'h0,       1, 32'hFFFF_FFFF, 32'h300,      32'h0,         32'h1000_0104, 0, 1);
    add(0, 0, 0, 32'h0,          0, 26'h0,       1, 32'h3C00_0300, 32'h304,      32'h3C00_0300, 32'h304,      1, 1);
    add(0, 0, 1, 32'hFFFF_FFFC,  0, 26'h0,       1, 32'h0,         32'hFFFF_FFFC, 32'h0,        32'h304,      0, 1);
    add(0, 0, 0, 32'h0,          0, 26'h0,       1, 32'h0C00_0000, 32'h0,        32'h0C00_0000, 32'h0,        1, 1);
    add(1, 0, 0, 32'h0,          0, 26'h0,       1, 32'hA000_0004, 32'h4,        32'h0C00_0000, 32'h0,        1, 0);
    add(1, 0, 1, 32'h40,         0, 26'h0,       0, 32'h0,         32'h40,       32'h0,         32'h0,        0, 1);
    add(0, 0, 0, 32'h0,          0, 26'h0,       1, 32'h1400_0040, 32'h44,       32'h1400_0040, 32'h44,       1, 1);
    add(1, 0, 0, 32'h0,          0, 26'h0,       0, 32'h0,         32'h44,       32'h1400_0040, 32'h44,       1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      logic [31:0] e_instr;
      v = vecs[i];
      e_instr = v.e_instr;
      stall = v.stall; flush = v.flush; branch_taken = v.br; branch_target = v.bt;
      jump = v.jmp; jump_index = v.ji; imem_ack = v.ack; imem_rdata = v.rd;
      @(posedge clk);
      #1;
      chk("pc", i, pc, v.e_pc);
      chk("imem_addr", i, imem_addr, v.e_pc);
      chk("id_instr", i, id_instr, v.e_instr);
      chk("id_pc_plus4", i, id_pc_plus4, v.e_pc4);
      chk("id_op_code", i, {26'd0, id_op_code}, {26'd0, e_instr[31:26]});
      chk("id_valid", i, {31'd0, id_valid}, {31'd0, v.e_valid});
      chk("imem_req", i, {31'd0, imem_req}, {31'd0, v.e_req});
    end
    idle_inputs();

    // Reset while a request is outstanding: the late ack answers the RESET_PC fetch.
    drive(0, 0, 32'h0, 0, 32'h0);
    rst = 1;
    @(posedge clk);
    #1;
    chk("midrst_pc", -1, pc, 32'h0);
    chk("midrst_req", -1, {31'd0, imem_req}, 32'd0);
    rst = 0;
    drive(0, 0, 32'h0, 1, 32'h2000_0007);
    chk("late_ack_instr", -1, id_instr, 32'h2000_0007);
    chk("late_ack_pc4", -1, id_pc_plus4, 32'h4);

`ifdef IF_PERF_CNT_EN
    do_reset();
    rst = 0;
    chk("perf_fetch_rst", -1, perf_fetch_cnt, 32'd0);
    chk("perf_stall_rst", -1, perf_stall_cnt, 32'd0);
    drive(0, 0, 32'h0,  1, 32'h1);
    drive(0, 0, 32'h0,  1, 32'h2);
    drive(0, 0, 32'h0,  1, 32'h3);
    drive(0, 1, 32'h80, 0, 32'h0);
    drive(0, 0, 32'h0,  1, 32'hBAD);
    drive(0, 0, 32'h0,  1, 32'h4);
    drive(0, 0, 32'h0,  1, 32'h5);
    drive(1, 0, 32'h0,  0, 32'h0);
    drive(1, 0, 32'h0,  0, 32'h0);
    drive(0, 0, 32'h0,  0, 32'h0);
    chk("perf_fetch", -1, perf_fetch_cnt, 32'd5);
    chk("perf_stall", -1, perf_stall_cnt, 32'd2);
    chk("perf_pc", -1, pc, 32'h88);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
